orbit_engine: RTL
=================

// Module: orbit_engine
// PURPOSE
//  Parametrised successor of the single-scene orbit controller for the gravity game.
//  Tracks game mode (welcome / free flight / orbit / launch) and which of NUM_PLANETS bodies holds the vessel.
//  Produces orbit angle (theta) and moon angle (moontheta) for the sprite/draw logic.
//  Advances once per frame_clk (one tick per video frame).
// PARAMETERS
//  NUM_PLANETS  8     number of planet slots (1..16)
//  COORD_W      10    width of unsigned X/Y/size coordinates (pixels)
//  THETA_W      9     width of theta/moontheta
//  THETA_MAX    360   theta wraps to 0 when it would reach this value
//  THETA_STEP   2     theta increment per frame while in ORBIT
//  MOON_STEP    3     moontheta increment per frame
// PORTS
//  frame_clk    in   1                    frame-rate clock, all state on rising edge
//  Reset_n      in   1                    asynchronous active-low reset
//  keycode      in   16                   current USB keycode (0x28 Enter, 0x2C Space, 0 = none)
//  planet_x     in   NUM_PLANETS*COORD_W  packed planet centre X, slot i at [i*COORD_W +: COORD_W]
//  planet_y     in   NUM_PLANETS*COORD_W  packed planet centre Y
//  planet_s     in   NUM_PLANETS*COORD_W  packed planet radius
//  planet_en    in   NUM_PLANETS          slot enable; disabled slots never capture
//  vessel_x     in   COORD_W              vessel centre X
//  vessel_y     in   COORD_W              vessel centre Y
//  vessel_s     in   COORD_W              vessel radius
//  state        out  2                    0 WELCOME, 1 FREE, 2 ORBIT, 3 LAUNCH
//  curplan      out  $clog2(NUM_PLANETS)  captured/last-captured planet index (min width 1)
//  welcomepage  out  1                    high iff state==WELCOME
//  theta        out  THETA_W              orbit angle, valid in ORBIT
//  moontheta    out  THETA_W              moon angle
//  near_any     out  1                    vessel inside capture box of some enabled, non-blocked planet
// BEHAVIOUR
//  Reset (async, Reset_n=0):
//   - state=WELCOME, curplan=0, theta=0, moontheta=0, welcomepage=1, near_any=0 (registered), block=0.
//   - Deassertion is synchronised; first state update occurs on the 2nd rising edge after release.
//  Key edge detection:
//   - keycode registered each cycle.
//   - enter_edge = (keycode==0x28) && (prev!=0x28); space_edge likewise for 0x2C.
//   - Holding a key produces one edge only.
//  Capture box for slot i: |vx-px| <= ps+vs AND |vy-py| <= ps+vs.
//   - Differences formed at COORD_W+1 bits signed; sums at COORD_W+1 bits unsigned; no wrap.
//   - When several slots hit, the lowest index wins (priority encoder).
//  Transitions (evaluated each rising edge):
//   - WELCOME: enter_edge -> FREE. All other keys ignored.
//   - FREE: space_edge && hit -> ORBIT; curplan <= winning index; theta <= 0.
//     space_edge with no hit: stay in FREE.
//   - ORBIT: theta <= theta+THETA_STEP; if the result >= THETA_MAX, subtract THETA_MAX (wrap).
//     space_edge -> LAUNCH. enter_edge ignored.
//   - LAUNCH: held exactly 1 cycle -> FREE; theta holds its value; block <= 1.
//  Re-capture block:
//   - While block=1, slot curplan is excluded from hit and near_any.
//   - block clears on the first cycle the vessel is outside that slot's box.
//   - Other slots may capture while block=1.
//  Simultaneous events:
//   - Space and Enter cannot both be edges (single keycode).
//   - A planet_en drop on curplan while in ORBIT forces FREE next cycle without LAUNCH or block.
//  Latency:
//   - state, curplan and theta update 1 cycle after the edge cycle.
//   - near_any is registered, 1 cycle after the coordinates.
// CONFIGURATION
//  ORBIT_MOON_EN defined:
//   - moontheta += MOON_STEP every cycle in FREE/ORBIT/LAUNCH, same wrap rule as theta.
//   - moontheta frozen in WELCOME.
//  ORBIT_MOON_EN undefined:
//   - moontheta tied to 0; no counter logic.
// TESTING
//  - Reset_n=0 mid-ORBIT -> all outputs reach reset values immediately (async); state=0, welcomepage=1.
//  - WELCOME, keycode 0x28 held 20 cycles -> state=1 after 1 cycle; a single transition only.
//  - FREE, vessel (350,250) s=10, planet0 (350,250) s=10, Space edge -> state=2, curplan=0, theta=0; theta=2 next cycle.
//  - Vessel inside boxes of slots 3 and 6, Space -> curplan=3.
//  - ORBIT 180 cycles (THETA_STEP 2) -> theta wraps 358->0; Space -> state=3 for one cycle, then 1.
//  - After launch, vessel still on planet0, Space -> stays FREE.
//    Move vessel to (30,30), then back to planet0, Space -> ORBIT, curplan=0.

Source files
------------

// File: rtl/orbit_engine.sv
// rtl/orbit_engine.sv - gravity-game orbit controller: mode FSM, planet capture, orbit/moon angles
// Optional feature macro: ORBIT_MOON_EN (moon angle counter; moontheta tied to 0 when undefined)
module orbit_engine #(
    parameter int NUM_PLANETS = 8,
    parameter int COORD_W     = 10,
    parameter int THETA_W     = 9,
    parameter int THETA_MAX   = 360,
    parameter int THETA_STEP  = 2,
    parameter int MOON_STEP   = 3,
    localparam int CP_W       = (NUM_PLANETS > 1) ? $clog2(NUM_PLANETS) : 1
) (
    input  logic                           frame_clk,
    input  logic                           Reset_n,
    input  logic [15:0]                    keycode,
    input  logic [NUM_PLANETS*COORD_W-1:0] planet_x,
    input  logic [NUM_PLANETS*COORD_W-1:0] planet_y,
    input  logic [NUM_PLANETS*COORD_W-1:0] planet_s,
    input  logic [NUM_PLANETS-1:0]         planet_en,
    input  logic [COORD_W-1:0]             vessel_x,
    input  logic [COORD_W-1:0]             vessel_y,
    input  logic [COORD_W-1:0]             vessel_s,
    output logic [1:0]                     state,
    output logic [CP_W-1:0]                curplan,
    output logic                           welcomepage,
    output logic [THETA_W-1:0]             theta,
    output logic [THETA_W-1:0]             moontheta,
    output logic                           near_any
);

    typedef enum logic [1:0] {
        ST_WELCOME = 2'd0,
        ST_FREE    = 2'd1,
        ST_ORBIT   = 2'd2,
        ST_LAUNCH  = 2'd3
    } state_t;

    localparam logic [THETA_W:0] T_MAX  = (THETA_W+1)'(THETA_MAX);
    localparam logic [THETA_W:0] T_STEP = (THETA_W+1)'(THETA_STEP);

    function automatic logic [THETA_W-1:0] wrap_add(input logic [THETA_W-1:0] v,
                                                     input logic [THETA_W:0]   step);
        logic [THETA_W:0] s;
        s = {1'b0, v} + step;
        if (s >= T_MAX)
            s = s - T_MAX;
        return s[THETA_W-1:0];
    endfunction

    state_t              state_q, state_d;
    logic [CP_W-1:0]     curplan_q, curplan_d;
    logic [THETA_W-1:0]  theta_q, theta_d;
    logic                block_q, block_d;
    logic                near_q;
    logic                run_q;
    logic [15:0]         key_q;
    logic [NUM_PLANETS-1:0] in_box, hit;
    logic [CP_W-1:0]     hit_idx;
    logic                any_hit, cur_in_box;
    logic                enter_edge, space_edge;

    assign enter_edge = (keycode == 16'h0028) && (key_q != 16'h0028);
    assign space_edge = (keycode == 16'h002C) && (key_q != 16'h002C);

    for (genvar i = 0; i < NUM_PLANETS; i++) begin : g_box
        logic signed [COORD_W:0] dx, dy;
        logic [COORD_W:0]        adx, ady, lim;
        assign dx  = $signed({1'b0, vessel_x}) - $signed({1'b0, planet_x[i*COORD_W +: COORD_W]});
        assign dy  = $signed({1'b0, vessel_y}) - $signed({1'b0, planet_y[i*COORD_W +: COORD_W]});
        assign adx = dx[COORD_W] ? $unsigned(-dx) : $unsigned(dx);
        assign ady = dy[COORD_W] ? $unsigned(-dy) : $unsigned(dy);
        assign lim = {1'b0, planet_s[i*COORD_W +: COORD_W]} + {1'b0, vessel_s};
        assign in_box[i] = (adx <= lim) && (ady <= lim);
        // The planet just launched from stays invisible until the vessel has left its box.
        assign hit[i] = planet_en[i] && in_box[i] && !(block_q && (curplan_q == CP_W'(i)));
    end

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_PLANETS - 1; i >= 0; i--)
            if (hit[i])
                hit_idx = CP_W'(i);
    end

    assign any_hit    = |hit;
    assign cur_in_box = in_box[curplan_q];

    always_comb begin
        state_d   = state_q;
        curplan_d = curplan_q;
        theta_d   = theta_q;
        block_d   = block_q;
        if (block_q && !cur_in_box)
            block_d = 1'b0;
        case (state_q)
            ST_WELCOME: if (enter_edge) state_d = ST_FREE;
            ST_FREE: begin
                if (space_edge && any_hit) begin
                    state_d   = ST_ORBIT;
                    curplan_d = hit_idx;
                    theta_d   = '0;
                    block_d   = 1'b0;
                end
            end
            ST_ORBIT: begin
                theta_d = wrap_add(theta_q, T_STEP);
                if (!planet_en[curplan_q])
                    state_d = ST_FREE;
                else if (space_edge)
                    state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_d = ST_FREE;
                block_d = 1'b1;
            end
            default: state_d = ST_WELCOME;
        endcase
    end

    // run_q delays the first state update to the second edge after reset release.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            run_q     <= 1'b0;
            state_q   <= ST_WELCOME;
            curplan_q <= '0;
            theta_q   <= '0;
            block_q   <= 1'b0;
            near_q    <= 1'b0;
            key_q     <= '0;
        end else begin
            run_q <= 1'b1;
            if (run_q) begin
                state_q   <= state_d;
                curplan_q <= curplan_d;
                theta_q   <= theta_d;
                block_q   <= block_d;
                near_q    <= any_hit;
                key_q     <= keycode;
            end
        end
    end

`ifdef ORBIT_MOON_EN
    logic [THETA_W-1:0] moon_q;
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n)
            moon_q <= '0;
        else if (run_q && (state_q != ST_WELCOME))
            moon_q <= wrap_add(moon_q, (THETA_W+1)'(MOON_STEP));
    end
    assign moontheta = moon_q;
`else
    assign moontheta = '0;
`endif

    assign state       = state_q;
    assign curplan     = curplan_q;
    assign theta       = theta_q;
    assign near_any    = near_q;
    assign welcomepage = (state_q == ST_WELCOME);

endmodule
